// File: rtl/sqrt_pkg.sv
// sqrt_pkg
// Shared definitions for the double-precision square-root control path:
// sequencer state encoding, result-select codes, operand-class flag bit
// positions, default iteration parameters and the special-operand classifier.
// No ports (package).

package sqrt_pkg;

  // Sequencer states, in the order an operation visits them.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRAP  = 3'd1,
    LOAD  = 3'd2,
    ITER  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Result select codes steering the output mux in the datapath.
  localparam logic [1:0] SEL_NORM = 2'b00;
  localparam logic [1:0] SEL_ZERO = 2'b01;
  localparam logic [1:0] SEL_INF  = 2'b10;
  localparam logic [1:0] SEL_NAN  = 2'b11;

  // Bit positions inside the in_flags operand-class vector.
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_INF  = 1;
  localparam int FLAG_NAN  = 2;

  // One root bit per iteration: 106-bit mantissa path / 2.
  localparam int DEFAULT_ITERS = 53;
  localparam int DEFAULT_CNT_W = 6;

  typedef struct packed {
    logic       invalid;
    logic [1:0] sel;
  } class_t;

  // Classify an operand into its result select and invalid flag.
  // NaN propagates quietly; any negative non-zero (including -inf) is an
  // invalid operation; zero keeps its sign in the datapath; +inf returns inf.
  function automatic class_t classify(input logic sign, input logic [2:0] flags);
    class_t c;
    c.invalid = 1'b0;
    c.sel     = SEL_NORM;
    if (flags[FLAG_NAN]) begin
      c.sel = SEL_NAN;
    end else if (sign && !flags[FLAG_ZERO]) begin
      c.sel     = SEL_NAN;
      c.invalid = 1'b1;
    end else if (flags[FLAG_ZERO]) begin
      c.sel = SEL_ZERO;
    end else if (flags[FLAG_INF]) begin
      c.sel = SEL_INF;
    end
    return c;
  endfunction

endpackage

// File: rtl/sqrt_iter_counter.sv
// sqrt_iter_counter
// Iteration index for the root core. Cleared when the core is loaded and
// advanced once per core step; flags the last iteration.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - force the count to zero (has priority over en)
//   en        - increment the count
//   cnt       - current iteration index
//   tc        - high while cnt == ITERS-1

module sqrt_iter_counter
  import sqrt_pkg::*;
#(
  parameter int ITERS = DEFAULT_ITERS,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over increment so a load always restarts at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == CNT_W'(ITERS - 1));

endmodule

// File: rtl/sqrt_sequencer.sv
// sqrt_sequencer
// Control unit for the double-precision square-root path: classifies the
// operand at request time, starts the input wrapper, waits for its hand-off,
// loads and steps the iterative root core ITERS times, loads the rounding
// register and pulses ready. abort flushes the current operation.
// Configuration macro: SQRT_SPECIAL_BYPASS_EN - when defined, special
// operands (out_sel != 00) go straight from IDLE to DONE.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   start       - request pulse, sampled only in IDLE
//   sign        - operand sign
//   in_flags    - operand class [0] zero, [1] inf, [2] NaN
//   abort       - flush the current operation
//   wrap_done   - input wrapper hand-off
//   wrap_start  - one-cycle start pulse to the input wrapper
//   core_ld     - load root core from wrapper outputs
//   core_step   - advance root core one iteration
//   iter_cnt    - current iteration index
//   round_ld    - load rounding/output register
//   out_sel     - result select (00 normal, 01 zero, 10 inf, 11 NaN)
//   invalid     - IEEE invalid-operation flag for this result
//   busy        - high in every state except IDLE
//   ready       - one-cycle result-valid pulse

module sqrt_sequencer
  import sqrt_pkg::*;
#(
  parameter int ITERS = DEFAULT_ITERS,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [2:0]       in_flags,
  input  logic             abort,
  input  logic             wrap_done,
  output logic             wrap_start,
  output logic             core_ld,
  output logic             core_step,
  output logic [CNT_W-1:0] iter_cnt,
  output logic             round_ld,
  output logic [1:0]       out_sel,
  output logic             invalid,
  output logic             busy,
  output logic             ready
);

  state_e     state_q, state_d;
  logic [1:0] out_sel_q, out_sel_d;
  logic       invalid_q, invalid_d;
  logic       wrap_first_q, wrap_first_d;
  logic       last_iter;
  class_t     cls;

  // Iteration counter: restarts in LOAD, counts every ITER cycle.
  sqrt_iter_counter #(
    .ITERS (ITERS),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk (clk),
    .rst (rst),
    .clr (state_q == LOAD),
    .en  (state_q == ITER),
    .cnt (iter_cnt),
    .tc  (last_iter)
  );

  assign cls = classify(sign, in_flags);

  // Next-state logic. The classification is captured only when a request
  // is accepted, so it stays stable across the whole operation and after
  // an abort. abort overrides every transition out of a busy state.
  always_comb begin
    state_d   = state_q;
    out_sel_d = out_sel_q;
    invalid_d = invalid_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          out_sel_d = cls.sel;
          invalid_d = cls.invalid;
`ifdef SQRT_SPECIAL_BYPASS_EN
          state_d   = (cls.sel != SEL_NORM) ? DONE : WRAP;
`else
          state_d   = WRAP;
`endif
        end
      end
      WRAP:    if (wrap_done) state_d = LOAD;
      LOAD:    state_d = ITER;
      ITER:    if (last_iter) state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
    // WRAP is only ever entered from IDLE, so this marks its first cycle.
    wrap_first_d = (state_q == IDLE) && (state_d == WRAP);
  end

  // State and result-classification registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      out_sel_q    <= SEL_NORM;
      invalid_q    <= 1'b0;
      wrap_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_sel_q    <= out_sel_d;
      invalid_q    <= invalid_d;
      wrap_first_q <= wrap_first_d;
    end
  end

  // All outputs decode registered state only.
  assign wrap_start = (state_q == WRAP) && wrap_first_q;
  assign core_ld    = (state_q == LOAD);
  assign core_step  = (state_q == ITER);
  assign round_ld   = (state_q == ROUND);
  assign ready      = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_sel    = out_sel_q;
  assign invalid    = invalid_q;

endmodule

// File: tb/tb_sqrt_sequencer.sv
// tb_sqrt_sequencer
// Directed bench for sqrt_sequencer. A cycle-timeline model derived from the
// operation timing (start cycle, wrapper hand-off cycle, fixed iteration
// count) predicts every output each cycle; literal checks pin the model.

module tb_sqrt_sequencer;

  localparam int ITERS = 53;
  localparam int CNT_W = 6;
`ifdef SQRT_SPECIAL_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum {P_IDLE, P_WRAP, P_LOAD, P_ITER, P_ROUND, P_DONE} phase_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sign;
  logic [2:0]       in_flags;
  logic             abort;
  logic             wrap_done;
  logic             wrap_start;
  logic             core_ld;
  logic             core_step;
  logic [CNT_W-1:0] iter_cnt;
  logic             round_ld;
  logic [1:0]       out_sel;
  logic             invalid;
  logic             busy;
  logic             ready;
  logic [8:0]       ctrl;

  int vectors = 0;
  int miscompares = 0;

  // Model state: whether an operation is in flight, the cycle its start
  // was accepted, the cycle the wrapper handed off (-1 if not yet), and
  // the classification captured at acceptance.
  int         cyc = 0;
  bit         chk_en = 1'b0;
  bit         m_active = 1'b0;
  bit         m_byp = 1'b0;
  int         m_t0 = 0;
  int         m_k = -1;
  logic [1:0] m_sel = 2'b00;
  logic       m_inv = 1'b0;

  // Per-operation tallies gathered from the DUT outputs.
  int         op_t0 = 0;
  int         step_cnt, round_cnt, ready_cnt, wrap_start_cnt, core_ld_cnt, ready_rel;
  logic [1:0] sel_at_ready;
  logic       inv_at_ready;

  assign ctrl = {wrap_start, core_ld, core_step, round_ld, ready, busy, invalid, out_sel};

  sqrt_sequencer #(
    .ITERS (ITERS),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sign       (sign),
    .in_flags   (in_flags),
    .abort      (abort),
    .wrap_done  (wrap_done),
    .wrap_start (wrap_start),
    .core_ld    (core_ld),
    .core_step  (core_step),
    .iter_cnt   (iter_cnt),
    .round_ld   (round_ld),
    .out_sel    (out_sel),
    .invalid    (invalid),
    .busy       (busy),
    .ready      (ready)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Compares one value and logs a FAIL line when it differs.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one cycle of inputs and waits until just after the edge that
  // samples them.
  task automatic applyStimulus(input logic st, input logic sg, input logic [2:0] fl,
                               input logic ab, input logic wd, input logic rs);
    start     = st;
    sign      = sg;
    in_flags  = fl;
    abort     = ab;
    wrap_done = wd;
    rst       = rs;
    @(posedge clk);
    #1;
  endtask

  // Reference classification from the operand rules.
  function automatic logic [2:0] ref_class(input logic s, input logic [2:0] f);
    if (f[2])            return 3'b011;
    else if (s && !f[0]) return 3'b111;
    else if (f[0])       return 3'b001;
    else if (f[1] && !s) return 3'b010;
    else                 return 3'b000;
  endfunction

  // Which phase the operation is in during cycle c, by offset from the
  // wrapper hand-off: LOAD at k+1, ITER k+2..k+ITERS+1, ROUND k+ITERS+2,
  // DONE k+ITERS+3. A bypassed operand is in DONE the cycle after start.
  function automatic phase_t phase_of(input int c);
    int d;
    if (!m_active) return P_IDLE;
    if (m_byp)     return P_DONE;
    if (m_k < 0)   return P_WRAP;
    d = c - m_k;
    if (d == 1)          return P_LOAD;
    if (d <= ITERS + 1)  return P_ITER;
    if (d == ITERS + 2)  return P_ROUND;
    return P_DONE;
  endfunction

  // Model update on each rising edge using the inputs held through the
  // cycle that is ending.
  always @(posedge clk) begin
    phase_t ph;
    logic [2:0] c3;
    ph = phase_of(cyc);
    if (rst) begin
      m_active = 1'b0;
      m_sel    = 2'b00;
      m_inv    = 1'b0;
      chk_en   = 1'b1;
    end else if (!m_active) begin
      if (start) begin
        c3       = ref_class(sign, in_flags);
        m_sel    = c3[1:0];
        m_inv    = c3[2];
        m_active = 1'b1;
        m_t0     = cyc;
        m_k      = -1;
        m_byp    = BYPASS && (c3[1:0] != 2'b00);
      end
    end else if (abort || ph == P_DONE) begin
      m_active = 1'b0;
    end else if (ph == P_WRAP && wrap_done) begin
      m_k = cyc;
    end
    cyc++;
  end

  // Single compare process: every cycle, mid-cycle, check all outputs
  // against the model and tally events for the literal checks.
  always @(negedge clk) begin
    phase_t ph;
    logic [8:0] exp_ctrl;
    if (chk_en) begin
      ph = phase_of(cyc);
      exp_ctrl = {(ph == P_WRAP) && (cyc == m_t0 + 1), ph == P_LOAD, ph == P_ITER,
                  ph == P_ROUND, ph == P_DONE, ph != P_IDLE, m_inv, m_sel};
      checkOutput("ctrl", {23'd0, ctrl}, {23'd0, exp_ctrl});
      if (ph == P_ITER) checkOutput("iter_cnt", {26'd0, iter_cnt}, cyc - m_k - 2);
      if (core_step)  step_cnt++;
      if (round_ld)   round_cnt++;
      if (wrap_start) wrap_start_cnt++;
      if (core_ld)    core_ld_cnt++;
      if (ready) begin
        ready_cnt++;
        ready_rel    = cyc - op_t0;
        sel_at_ready = out_sel;
        inv_at_ready = invalid;
      end
    end
  end

  task automatic clearTallies();
    step_cnt = 0; round_cnt = 0; ready_cnt = 0;
    wrap_start_cnt = 0; core_ld_cnt = 0; ready_rel = -1;
    sel_at_ready = 2'b00; inv_at_ready = 1'b0;
  endtask

  // One request at relative cycle 0, wrap_done in relative cycle k,
  // optional abort and extra start pulses, run for a fixed window.
  task automatic runOp(input logic s, input logic [2:0] f, input int k,
                       input int abort_at, input int ign1, input int ign2);
    clearTallies();
    op_t0 = cyc;
    applyStimulus(1'b1, s, f, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c < 70; c++) begin
      applyStimulus((c == ign1) || (c == ign2), s, f, c == abort_at, c == k, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  // Directed sequence with literal expectations.
  initial begin
    clearTallies();
    start = 0; sign = 0; in_flags = 0; abort = 0; wrap_done = 0; rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ctrl", {23'd0, ctrl}, 32'd0);
    checkOutput("reset_iter_cnt", {26'd0, iter_cnt}, 32'd0);
    applyStimulus(0, 0, 3'b000, 0, 0, 0);

    // abort and wrap_done in IDLE have no effect
    applyStimulus(0, 0, 3'b000, 1, 1, 0);
    applyStimulus(0, 0, 3'b000, 0, 0, 0);

    // normal operand, hand-off in the first WRAP cycle
    runOp(0, 3'b000, 1, -1, -1, -1);
    checkOutput("norm_k1_ready_cyc", ready_rel, 57);
    checkOutput("norm_k1_ready_cnt", ready_cnt, 1);
    checkOutput("norm_k1_steps", step_cnt, ITERS);
    checkOutput("norm_k1_round", round_cnt, 1);
    checkOutput("norm_k1_core_ld", core_ld_cnt, 1);
    checkOutput("norm_k1_wrap_start", wrap_start_cnt, 1);
    checkOutput("norm_k1_sel", {30'd0, sel_at_ready}, 32'd0);

    // normal operand, hand-off 2 cycles after wrap_start
    runOp(0, 3'b000, 3, -1, -1, -1);
    checkOutput("norm_k3_ready_cyc", ready_rel, 59);
    checkOutput("norm_k3_steps", step_cnt, ITERS);

    // negative non-zero: invalid NaN
    runOp(1, 3'b000, 1, -1, -1, -1);
    checkOutput("neg_ready_cyc", ready_rel, BYPASS ? 1 : 57);
    checkOutput("neg_wrap_start", wrap_start_cnt, BYPASS ? 0 : 1);
    checkOutput("neg_steps", step_cnt, BYPASS ? 0 : ITERS);
    checkOutput("neg_sel", {30'd0, sel_at_ready}, 32'd3);
    checkOutput("neg_invalid", {31'd0, inv_at_ready}, 32'd1);

    // negative zero: zero result, valid
    runOp(1, 3'b001, 1, -1, -1, -1);
    checkOutput("nzero_steps", step_cnt, BYPASS ? 0 : ITERS);
    checkOutput("nzero_sel", {30'd0, sel_at_ready}, 32'd1);
    checkOutput("nzero_invalid", {31'd0, inv_at_ready}, 32'd0);

    // NaN, +inf, -inf classifications
    runOp(0, 3'b100, 1, -1, -1, -1);
    checkOutput("nan_sel", {29'd0, inv_at_ready, sel_at_ready}, 32'b011);
    runOp(0, 3'b010, 1, -1, -1, -1);
    checkOutput("pinf_sel", {29'd0, inv_at_ready, sel_at_ready}, 32'b010);
    runOp(1, 3'b010, 1, -1, -1, -1);
    checkOutput("ninf_sel", {29'd0, inv_at_ready, sel_at_ready}, 32'b111);

    // abort at iteration 20 (ITER starts at relative cycle 3)
    runOp(0, 3'b000, 1, 23, -1, -1);
    checkOutput("abort_ready_cnt", ready_cnt, 0);
    checkOutput("abort_round_cnt", round_cnt, 0);
    checkOutput("abort_steps", step_cnt, 21);
    runOp(0, 3'b000, 1, -1, -1, -1);
    checkOutput("post_abort_ready_cyc", ready_rel, 57);

    // start pulses during ITER and DONE are ignored
    runOp(0, 3'b000, 1, -1, 10, 57);
    checkOutput("ign_ready_cnt", ready_cnt, 1);
    checkOutput("ign_ready_cyc", ready_rel, 57);
    checkOutput("ign_steps", step_cnt, ITERS);
    checkOutput("ign_wrap_start", wrap_start_cnt, 1);

    // abort together with wrap_done: abort wins
    runOp(0, 3'b000, 2, 2, -1, -1);
    checkOutput("abort_wd_core_ld", core_ld_cnt, 0);
    checkOutput("abort_wd_ready", ready_cnt, 0);

    // reset in WRAP together with wrap_done
    clearTallies();
    op_t0 = cyc;
    applyStimulus(1, 0, 3'b100, 0, 0, 0);
    applyStimulus(0, 0, 3'b100, 0, 1, 1);
    @(negedge clk);
    checkOutput("rst_wrap_ctrl", {23'd0, ctrl}, 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 3'b000, 0, 0, 0);
    checkOutput("rst_wrap_core_ld", core_ld_cnt, 0);
    checkOutput("rst_wrap_ready", ready_cnt, BYPASS ? 1 : 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
